// File: rtl/pc_gen.sv
// Fetch-stage program counter with stall, branch/exception redirect and a one-entry
// pending-redirect buffer. Define PC_MISALIGN_CHK_EN to trap misaligned branch targets.
module pc_gen #(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(32'h0000_0100),
  parameter int unsigned       INC       = 4
) (
  input  logic              sys_clk,
  input  logic              rstn,
  input  logic              stall,
  input  logic              br_valid,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              exc_valid,
  output logic [ADDR_W-1:0] pc_addr,
  output logic              ce,
  output logic              redirect_taken,
  output logic              pend_valid,
  output logic              misalign_err
);

  localparam logic [ADDR_W-1:0] IncVal = ADDR_W'(INC);

  typedef enum logic [1:0] {StIdle, StRun, StHold} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic              pend_valid_q, pend_valid_d;
  logic              ce_q, ce_d;
  logic              redirect_q, redirect_d;
  logic              misalign_q, misalign_d;
  logic              br_bad;

`ifdef PC_MISALIGN_CHK_EN
  localparam logic [ADDR_W-1:0] AlignMask = ADDR_W'(INC - 1);
  assign br_bad = |(br_target & AlignMask);
`else
  assign br_bad = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pend_addr_d  = pend_addr_q;
    pend_valid_d = pend_valid_q;
    ce_d         = ce_q;
    redirect_d   = 1'b0;
    misalign_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        // First fetch presents RESET_VEC with ce raised; redirects are ignored here.
        ce_d    = 1'b1;
        state_d = StRun;
      end
      StRun, StHold: begin
        ce_d = 1'b1;
        if (exc_valid) begin
          pc_d         = EXC_VEC;
          pend_valid_d = 1'b0;
          redirect_d   = 1'b1;
          state_d      = StRun;
        end else if (br_valid && br_bad) begin
          // A misaligned target is never loaded or buffered, even under stall.
          pc_d         = EXC_VEC;
          pend_valid_d = 1'b0;
          redirect_d   = 1'b1;
          misalign_d   = 1'b1;
          state_d      = StRun;
        end else if (br_valid && !stall) begin
          pc_d         = br_target;
          pend_valid_d = 1'b0;
          redirect_d   = 1'b1;
          state_d      = StRun;
        end else if (br_valid) begin
          pend_addr_d  = br_target;
          pend_valid_d = 1'b1;
          state_d      = StHold;
        end else if (stall) begin
          pc_d = pc_q;
        end else if (state_q == StHold) begin
          pc_d         = pend_addr_q;
          pend_valid_d = 1'b0;
          redirect_d   = 1'b1;
          state_d      = StRun;
        end else begin
          pc_d = pc_q + IncVal;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rstn) begin
      state_q      <= StIdle;
      pc_q         <= RESET_VEC;
      pend_addr_q  <= '0;
      pend_valid_q <= 1'b0;
      ce_q         <= 1'b0;
      redirect_q   <= 1'b0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pend_addr_q  <= pend_addr_d;
      pend_valid_q <= pend_valid_d;
      ce_q         <= ce_d;
      redirect_q   <= redirect_d;
      misalign_q   <= misalign_d;
    end
  end

  assign pc_addr        = pc_q;
  assign ce             = ce_q;
  assign redirect_taken = redirect_q;
  assign pend_valid     = pend_valid_q;
  assign misalign_err   = misalign_q;

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: a 32-bit default instance and an 8-bit instance for wrap.
module tb_pc_gen;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic        ce;
    logic        rt;
    logic        pv;
    logic        me;
  } exp_t;

  logic        sys_clk;
  logic        rstn;
  logic        stall;
  logic        br_valid;
  logic [31:0] br_target;
  logic        exc_valid;

  logic [31:0] pc_a;
  logic        ce_a, rt_a, pv_a, me_a;
  logic [7:0]  pc_b;
  logic        ce_b, rt_b, pv_b, me_b;

  exp_t qa[$];
  exp_t qb[$];
  int   checks   = 0;
  int   failures = 0;

  pc_gen u_dut_a (
    .sys_clk        (sys_clk),
    .rstn           (rstn),
    .stall          (stall),
    .br_valid       (br_valid),
    .br_target      (br_target),
    .exc_valid      (exc_valid),
    .pc_addr        (pc_a),
    .ce             (ce_a),
    .redirect_taken (rt_a),
    .pend_valid     (pv_a),
    .misalign_err   (me_a)
  );

  pc_gen #(
    .ADDR_W    (8),
    .RESET_VEC (8'hF0),
    .EXC_VEC   (8'h40),
    .INC       (4)
  ) u_dut_b (
    .sys_clk        (sys_clk),
    .rstn           (rstn),
    .stall          (stall),
    .br_valid       (br_valid),
    .br_target      (br_target[7:0]),
    .exc_valid      (exc_valid),
    .pc_addr        (pc_b),
    .ce             (ce_b),
    .redirect_taken (rt_b),
    .pend_valid     (pv_b),
    .misalign_err   (me_b)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic compare(input string who, input exp_t e, input logic [31:0] pc,
                         input logic c, input logic r, input logic p, input logic m);
    checks++;
    if ({pc, c, r, p, m} !== {e.pc, e.ce, e.rt, e.pv, e.me}) begin
      failures++;
      $display("FAIL %s/%s: got pc=%h ce=%b rt=%b pv=%b me=%b, want pc=%h ce=%b rt=%b pv=%b me=%b",
               who, e.tag, pc, c, r, p, m, e.pc, e.ce, e.rt, e.pv, e.me);
    end
  endtask

  // Monitor: outputs are registered, so every cycle after an edge is a presented response.
  initial begin
    exp_t e;
    forever begin
      @(posedge sys_clk);
      #2;
      if (qa.size() > 0) begin
        e = qa.pop_front();
        compare("a", e, pc_a, ce_a, rt_a, pv_a, me_a);
      end
      if (qb.size() > 0) begin
        e = qb.pop_front();
        compare("b", e, {24'h0, pc_b}, ce_b, rt_b, pv_b, me_b);
      end
    end
  end

  // Drive one cycle of inputs and queue the outputs expected after the following edge.
  task automatic step(input bit sel, input string tag, input bit r, input bit s, input bit bv,
                      input logic [31:0] bt, input bit e, input logic [31:0] pc, input bit c,
                      input bit rt, input bit pv, input bit me);
    exp_t x;
    rstn      = r;
    stall     = s;
    br_valid  = bv;
    br_target = bt;
    exc_valid = e;
    x.tag = tag; x.pc = pc; x.ce = c; x.rt = rt; x.pv = pv; x.me = me;
    @(posedge sys_clk);
    if (sel) qb.push_back(x);
    else     qa.push_back(x);
    #1;
  endtask

  logic [31:0] p;
  bit          mchk;

  initial begin
`ifdef PC_MISALIGN_CHK_EN
    mchk = 1'b1;
`else
    mchk = 1'b0;
`endif
    rstn = 1'b1; stall = 1'b0; br_valid = 1'b0; br_target = '0; exc_valid = 1'b0;
    #1;
    //        sel tag       r  s  bv bt       e  pc       ce rt pv me
    for (int i = 0; i < 3; i++)
      step(0, "reset",    1, 0, 0, 32'h0,   0, 32'h0,   0, 0, 0, 0);
    step(0, "release",  0, 0, 0, 32'h0,   0, 32'h0,   1, 0, 0, 0);
    step(0, "seq4",     0, 0, 0, 32'h0,   0, 32'h4,   1, 0, 0, 0);
    step(0, "seq8",     0, 0, 0, 32'h0,   0, 32'h8,   1, 0, 0, 0);
    step(0, "seqc",     0, 0, 0, 32'h0,   0, 32'hC,   1, 0, 0, 0);
    step(0, "seq10",    0, 0, 0, 32'h0,   0, 32'h10,  1, 0, 0, 0);
    step(0, "br200",    0, 0, 1, 32'h200, 0, 32'h200, 1, 1, 0, 0);
    step(0, "seq204",   0, 0, 0, 32'h0,   0, 32'h204, 1, 0, 0, 0);
    step(0, "br20",     0, 0, 1, 32'h20,  0, 32'h20,  1, 1, 0, 0);
    step(0, "stbr80",   0, 1, 1, 32'h80,  0, 32'h20,  1, 0, 1, 0);
    step(0, "hold1",    0, 1, 0, 32'h0,   0, 32'h20,  1, 0, 1, 0);
    step(0, "hold2",    0, 1, 0, 32'h0,   0, 32'h20,  1, 0, 1, 0);
    step(0, "rel80",    0, 0, 0, 32'h0,   0, 32'h80,  1, 1, 0, 0);
    step(0, "seq84",    0, 0, 0, 32'h0,   0, 32'h84,  1, 0, 0, 0);
    step(0, "excall",   0, 1, 1, 32'h300, 1, 32'h100, 1, 1, 0, 0);
    step(0, "stbr40",   0, 1, 1, 32'h40,  0, 32'h100, 1, 0, 1, 0);
    step(0, "stbr60",   0, 1, 1, 32'h60,  0, 32'h100, 1, 0, 1, 0);
    step(0, "br70sup",  0, 0, 1, 32'h70,  0, 32'h70,  1, 1, 0, 0);
    step(0, "seq74",    0, 0, 0, 32'h0,   0, 32'h74,  1, 0, 0, 0);
    step(0, "stbr90",   0, 1, 1, 32'h90,  0, 32'h74,  1, 0, 1, 0);
    step(0, "excstall", 0, 1, 0, 32'h0,   1, 32'h100, 1, 1, 0, 0);
    step(0, "seq104",   0, 0, 0, 32'h0,   0, 32'h104, 1, 0, 0, 0);
    if (mchk) begin
      step(0, "br202",  0, 0, 1, 32'h202, 0, 32'h100, 1, 1, 0, 1);
      step(0, "aft202", 0, 0, 0, 32'h0,   0, 32'h104, 1, 0, 0, 0);
    end else begin
      step(0, "br202",  0, 0, 1, 32'h202, 0, 32'h202, 1, 1, 0, 0);
      step(0, "aft202", 0, 0, 0, 32'h0,   0, 32'h206, 1, 0, 0, 0);
    end
    step(0, "excmis",   0, 0, 1, 32'h202, 1, 32'h100, 1, 1, 0, 0);
    if (mchk) begin
      step(0, "stbr203", 0, 1, 1, 32'h203, 0, 32'h100, 1, 1, 0, 1);
      step(0, "rel203",  0, 0, 0, 32'h0,   0, 32'h104, 1, 0, 0, 0);
      p = 32'h104;
    end else begin
      step(0, "stbr203", 0, 1, 1, 32'h203, 0, 32'h100, 1, 0, 1, 0);
      step(0, "rel203",  0, 0, 0, 32'h0,   0, 32'h203, 1, 1, 0, 0);
      p = 32'h203;
    end
    step(0, "stbr400",  0, 1, 1, 32'h400, 0, p,       1, 0, 1, 0);
    step(0, "rsthold",  1, 1, 0, 32'h0,   0, 32'h0,   0, 0, 0, 0);
    step(0, "rel3",     0, 0, 0, 32'h0,   0, 32'h0,   1, 0, 0, 0);
    step(0, "seq4b",    0, 0, 0, 32'h0,   0, 32'h4,   1, 0, 0, 0);

    // 8-bit instance: RESET_VEC 0xF0 wraps through 0x00.
    step(1, "b_reset",  1, 0, 0, 32'h0,   0, 32'hF0,  0, 0, 0, 0);
    step(1, "b_reset2", 1, 0, 0, 32'h0,   0, 32'hF0,  0, 0, 0, 0);
    step(1, "b_rel",    0, 0, 0, 32'h0,   0, 32'hF0,  1, 0, 0, 0);
    step(1, "b_f4",     0, 0, 0, 32'h0,   0, 32'hF4,  1, 0, 0, 0);
    step(1, "b_f8",     0, 0, 0, 32'h0,   0, 32'hF8,  1, 0, 0, 0);
    step(1, "b_fc",     0, 0, 0, 32'h0,   0, 32'hFC,  1, 0, 0, 0);
    step(1, "b_wrap",   0, 0, 0, 32'h0,   0, 32'h00,  1, 0, 0, 0);
    step(1, "b_04",     0, 0, 0, 32'h0,   0, 32'h04,  1, 0, 0, 0);
    step(1, "b_stbr",   0, 1, 1, 32'h80,  0, 32'h04,  1, 0, 1, 0);
    step(1, "b_rsthld", 1, 1, 0, 32'h0,   0, 32'hF0,  0, 0, 0, 0);
    step(1, "b_rel2",   0, 0, 0, 32'h0,   0, 32'hF0,  1, 0, 0, 0);
    step(1, "b_f4b",    0, 0, 0, 32'h0,   0, 32'hF4,  1, 0, 0, 0);

    repeat (3) @(posedge sys_clk);
    #3;
    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d/%0d entries left, want 0/0", qa.size(), qb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised next-generation program counter for the uniprocessor fetch stage.
- Drives the instruction memory address and chip enable.
- Adds over the basic incrementing PC: configurable width, reset vector and increment; fetch stall; branch/jump redirect; exception redirect; a one-entry pending-redirect buffer that captures redirects arriving during a stall.

Parameters:
ADDR_W, 32, PC/address width in bits (>= 8)
RESET_VEC, 32'h0000_0000, first fetch address after reset (ADDR_W bits)
EXC_VEC, 32'h0000_0100, exception handler address (ADDR_W bits)
INC, 4, sequential increment in bytes (power of two, < 2^ADDR_W)

Ports:
sys_clk  input  1  system clock, all state on rising edge
rstn  input  1  synchronous reset, active-high: 1 sampled at a sys_clk rising edge resets the block
stall  input  1  hold current PC (fetch/decode back-pressure)
br_valid  input  1  branch/jump redirect request, single-cycle
br_target  input  ADDR_W  redirect target address
exc_valid  input  1  exception redirect request, single-cycle
pc_addr  output  ADDR_W  current instruction fetch address (registered)
ce  output  1  instruction memory enable (registered)
redirect_taken  output  1  one-cycle pulse: pc_addr loaded from a non-sequential source this cycle
pend_valid  output  1  a stalled redirect is buffered
misalign_err  output  1  see Optional Feature; tied 0 when the feature is compiled out

Behaviour:
- Reset: rstn=1 at a rising edge forces the following, overriding all other inputs in that cycle:
  - ce=0, pc_addr=RESET_VEC
  - pend_valid=0, pend_addr=0
  - redirect_taken=0, misalign_err=0
  - state=IDLE
- States:
  - IDLE: after reset. First edge with rstn=0: ce<=1, pc_addr holds RESET_VEC, state->RUN. The first fetch is RESET_VEC with ce=1, one cycle after reset release. stall/br/exc are ignored in IDLE.
  - RUN: no buffered redirect.
  - HOLD: pend_valid=1.
- RUN/HOLD per-edge priority, highest first:
  1. exc_valid: pc<=EXC_VEC, stall ignored, pend_valid<=0, redirect_taken<=1, state->RUN.
  2. br_valid & !stall: pc<=br_target, pend_valid<=0, redirect_taken<=1, state->RUN. A new branch supersedes any buffered one.
  3. br_valid & stall: pc held, pend_addr<=br_target, pend_valid<=1, state->HOLD. A newer branch overwrites the buffered one.
  4. stall: pc held, redirect_taken<=0.
  5. HOLD & !stall: pc<=pend_addr, pend_valid<=0, redirect_taken<=1, state->RUN.
  6. Otherwise: pc<=pc+INC, truncated to ADDR_W (wraps modulo 2^ADDR_W), redirect_taken<=0.
- ce stays 1 in RUN/HOLD. It goes to 0 only through reset.
- Latency: every redirect appears on pc_addr exactly one edge after it is accepted. No combinational path from any input to any output.
- Reset asserted mid-stall or mid-HOLD discards the buffered redirect.

Optional Feature:
- Macro: PC_MISALIGN_CHK_EN.
- Defined:
  - A br_target with any of bits [log2(INC)-1:0] nonzero is treated as misaligned.
  - On acceptance (rule 2 or 3): the target is not loaded or buffered; pc<=EXC_VEC, misalign_err<=1 for one cycle, redirect_taken<=1, pend_valid<=0.
  - exc_valid in the same cycle still takes priority, and misalign_err stays 0.
- Undefined: no alignment check; targets are loaded verbatim; misalign_err is constant 0.

Test Plan:
- Reset/startup: rstn=1 for 3 cycles, then 0 with no other stimulus -> cycle after release: pc_addr=0x0, ce=1. Subsequent cycles: 0x4, 0x8, 0xC.
- Branch redirect: at pc=0x10 pulse br_valid with br_target=0x200 -> next pc_addr=0x200, redirect_taken=1 for one cycle, then 0x204.
- Stalled branch: stall=1 at pc=0x20 with br_valid, target 0x80; hold stall 3 cycles -> pc_addr stays 0x20, pend_valid=1. On stall release: pc_addr=0x80, pend_valid=0.
- Exception over stall and branch: stall=1, br_valid (target 0x300) and exc_valid together -> pc_addr=EXC_VEC 0x100, pend_valid=0.
- Wrap and reset mid-HOLD: ADDR_W=8, run from 0xFC -> 0x00. Assert rstn while pend_valid=1 -> pend_valid=0, pc_addr=RESET_VEC, ce=0.
- With PC_MISALIGN_CHK_EN: br_target=0x202 -> pc_addr=0x100, misalign_err=1 for one cycle. Without the macro: pc_addr=0x202.
